amm_rr_arbiter: RTL and testbench
=================================

Name: amm_rr_arbiter

Overview:
- Parametrised N-to-1 Avalon-MM arbiter for the memory checker datapath.
- Lets NUM_CH burst-capable Avalon-MM masters (test generators, CSR-side readers) share one Avalon-MM slave port to the memory controller.
- Arbitrates round-robin and holds the grant for the full length of a write burst.
- Routes pipelined read responses back to the issuing channel through an in-order tag FIFO.

Parameters:
NUM_CH, 4, number of master channels (>=2)
ADDR_W, 32, address width
DATA_W, 64, data width (multiple of 8)
BURST_W, 11, burstcount width
MAX_RD, 8, outstanding read commands tracked (power of 2)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
m_address  input  NUM_CH*ADDR_W  per-channel address, channel i at slice i
m_read  input  NUM_CH  per-channel read request
m_write  input  NUM_CH  per-channel write request
m_byteenable  input  NUM_CH*DATA_W/8  per-channel byteenable
m_burstcount  input  NUM_CH*BURST_W  per-channel burstcount
m_writedata  input  NUM_CH*DATA_W  per-channel write data
m_waitrequest  output  NUM_CH  per-channel waitrequest
m_readdatavalid  output  NUM_CH  per-channel read data valid
m_readdata  output  DATA_W  read data, broadcast to all channels
s_address  output  ADDR_W  to slave
s_read  output  1  to slave
s_write  output  1  to slave
s_byteenable  output  DATA_W/8  to slave
s_burstcount  output  BURST_W  to slave
s_writedata  output  DATA_W  to slave
s_readdatavalid  input  1  from slave
s_readdata  input  DATA_W  from slave
s_waitrequest  input  1  from slave

Behaviour:
- Single clock clk. Reset rst is synchronous and active-high.
- Reset values:
  - state=IDLE; last_grant=NUM_CH-1, so ch0 wins first.
  - tag FIFO empty; beat counters 0.
  - s_read=s_write=0; m_readdatavalid=0; m_waitrequest all 1.
- Request vector: req[i] = m_write[i] | (m_read[i] & !fifo_full).
- Non-granted channels always see m_waitrequest=1.
- FSM:
  - IDLE:
    - If any req, pick the first set bit searching from last_grant+1 with wrap-around. Register grant, update last_grant, go to CMD.
    - No req: stay in IDLE.
  - CMD:
    - Slave outputs are muxed from the granted channel. m_waitrequest[grant] = s_waitrequest.
    - Read accepted (s_read & !s_waitrequest): push {grant, burstcount} into the tag FIFO, go to IDLE.
    - Write beat accepted with burstcount<=1: go to IDLE.
    - Write beat accepted with burstcount>1: wr_left=burstcount-1, go to WR_BURST.
    - Granted channel drops both read and write before acceptance: no slave transaction, go to IDLE.
  - WR_BURST:
    - Grant is locked; s_write follows m_write[grant]. Master idle cycles mid-burst are allowed and keep the lock.
    - Each accepted beat decrements wr_left. The beat accepted with wr_left==1 returns to IDLE.
- Latency: a request seen in IDLE cycle N appears on the slave in cycle N+1. Back-to-back commands take a minimum of 2 cycles each (1 arbitration bubble).
- burstcount of 0 is treated as 1, both for write locking and for read tags.
- Read return path:
  - m_readdatavalid[i] = s_readdatavalid & (head.ch==i), combinational. m_readdata = s_readdata.
  - Head beat counter counts returned beats; the FIFO pops on the last beat of head.burstcount.
- FIFO boundaries:
  - Push and pop in the same cycle are both allowed; occupancy is unchanged.
  - When full (MAX_RD entries), reads are masked from arbitration; writes still arbitrate.
  - s_readdatavalid with the FIFO empty is ignored (no m_readdatavalid).
- Reset mid-operation: any burst is abandoned and the FIFO is flushed. In-flight read data arriving after reset is ignored.

Optional Feature:
AMM_ARB_FIXED_PRIO_EN
- Defined: IDLE grants the lowest-index requesting channel (ch0 highest priority); last_grant is unused.
- Undefined: round-robin as above.
- All other behaviour is identical in both builds.

Test Plan:
- All 4 channels issue single writes continuously, slave waitrequest=0 -> grants cycle 0,1,2,3,0; each channel sees exactly one accepted beat per 8 cycles.
- ch1 issues a write burst of 4 while ch0 and ch2 request -> s_write carries 4 ch1 beats with no interleave, then ch2 is granted (round-robin), then ch0.
- ch0 reads burst 3, then ch3 reads burst 2, slave returns 5 beats back-to-back -> m_readdatavalid[0] high for the first 3 beats, m_readdatavalid[3] for the last 2.
- MAX_RD=8 reads outstanding with no data returned, ch2 requests read and ch1 write -> ch2 stalls with waitrequest=1, ch1 write is accepted; the first returned read beat (burst 1) unblocks ch2 on the following arbitration.
- s_waitrequest held high 5 cycles during a CMD read by ch0 -> m_waitrequest[0]=1 for 5 cycles, slave command stable, a single FIFO push on acceptance.
- rst asserted in the middle of a write burst of 8 after 3 beats -> next cycle s_write=0, state IDLE, FIFO empty, ch0 is the next grant.

Source files
------------

// File: rtl/amm_rr_arbiter.sv
// amm_rr_arbiter: NUM_CH-to-1 Avalon-MM arbiter with write-burst locking and
// an in-order tag FIFO that steers pipelined read data back to its issuer.
// Default build arbitrates round-robin. Defining AMM_ARB_FIXED_PRIO_EN makes
// idle arbitration fixed-priority (ch0 highest) instead.
module amm_rr_arbiter #(
    parameter int NUM_CH  = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64,
    parameter int BURST_W = 11,
    parameter int MAX_RD  = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH*ADDR_W-1:0]     m_address,
    input  logic [NUM_CH-1:0]            m_read,
    input  logic [NUM_CH-1:0]            m_write,
    input  logic [NUM_CH*(DATA_W/8)-1:0] m_byteenable,
    input  logic [NUM_CH*BURST_W-1:0]    m_burstcount,
    input  logic [NUM_CH*DATA_W-1:0]     m_writedata,
    output logic [NUM_CH-1:0]            m_waitrequest,
    output logic [NUM_CH-1:0]            m_readdatavalid,
    output logic [DATA_W-1:0]            m_readdata,
    output logic [ADDR_W-1:0]            s_address,
    output logic                         s_read,
    output logic                         s_write,
    output logic [DATA_W/8-1:0]          s_byteenable,
    output logic [BURST_W-1:0]           s_burstcount,
    output logic [DATA_W-1:0]            s_writedata,
    input  logic                         s_readdatavalid,
    input  logic [DATA_W-1:0]            s_readdata,
    input  logic                         s_waitrequest
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PTR_W = $clog2(MAX_RD);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, CMD, WR_BURST} state_t;

    typedef struct packed {
        logic [CH_W-1:0]    ch;
        logic [BURST_W-1:0] bc;
    } tag_t;

    state_t             state_q;
    logic [CH_W-1:0]    grant_q;
    logic [BURST_W-1:0] wr_left_q;
`ifndef AMM_ARB_FIXED_PRIO_EN
    logic [CH_W-1:0]    last_grant_q;
`endif

    logic [ADDR_W-1:0]  ch_addr [NUM_CH];
    logic [BE_W-1:0]    ch_be   [NUM_CH];
    logic [BURST_W-1:0] ch_bc   [NUM_CH];
    logic [DATA_W-1:0]  ch_wd   [NUM_CH];
    logic [NUM_CH-1:0]  req;

    logic [CH_W-1:0]    pick;
    logic               pick_vld;
    logic [BURST_W-1:0] gnt_bc;
    logic               gnt_rd_only;
    logic               rd_blocked;
    logic               rd_acc;
    logic               wr_acc;

    tag_t               tag_mem [MAX_RD];
    tag_t               head;
    tag_t               push_tag;
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic [BURST_W-1:0] beat_q;
    logic               fifo_full;
    logic               fifo_empty;
    logic               rd_hit;
    logic               last_beat;
    logic               push;
    logic               pop;

    // Unpack the flat per-channel buses; reads are masked while the tag FIFO is full.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign ch_addr[i] = m_address[i*ADDR_W +: ADDR_W];
        assign ch_be[i]   = m_byteenable[i*BE_W +: BE_W];
        assign ch_bc[i]   = m_burstcount[i*BURST_W +: BURST_W];
        assign ch_wd[i]   = m_writedata[i*DATA_W +: DATA_W];
        assign req[i]     = m_write[i] | (m_read[i] & ~fifo_full);
    end

    // Idle arbitration: pick the next requesting channel.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        pick     = '0;
        pick_vld = 1'b0;
`ifdef AMM_ARB_FIXED_PRIO_EN
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req[CH_W'(i)]) begin
                pick     = CH_W'(i);
                pick_vld = 1'b1;
            end
        end
`else
        // Walk backwards so the closest channel after last_grant overwrites the others.
        for (int off = NUM_CH; off >= 1; off--) begin
            if (req[CH_W'((int'(last_grant_q) + off) % NUM_CH)]) begin
                pick     = CH_W'((int'(last_grant_q) + off) % NUM_CH);
                pick_vld = 1'b1;
            end
        end
`endif
    end

    // Slave command is muxed from the granted channel whenever a grant is held.
    assign gnt_bc       = ch_bc[grant_q];
    assign gnt_rd_only  = m_read[grant_q] & ~m_write[grant_q];
    assign s_address    = ch_addr[grant_q];
    assign s_byteenable = ch_be[grant_q];
    assign s_burstcount = gnt_bc;
    assign s_writedata  = ch_wd[grant_q];
    assign s_write      = (state_q != IDLE) & m_write[grant_q];
    assign s_read       = (state_q == CMD) & gnt_rd_only & ~fifo_full;
    assign rd_blocked   = (state_q == CMD) & gnt_rd_only & fifo_full;
    assign rd_acc       = s_read & ~s_waitrequest;
    assign wr_acc       = s_write & ~s_waitrequest;

    // Only the granted channel can see waitrequest low.
    always_comb begin
        m_waitrequest = '1;
        if (state_q != IDLE) begin
            m_waitrequest[grant_q] = s_waitrequest | rd_blocked;
        end
    end

    // Arbitration FSM: grant in IDLE, issue in CMD, hold the lock through a write burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q      <= IDLE;
            grant_q      <= '0;
            wr_left_q    <= '0;
`ifndef AMM_ARB_FIXED_PRIO_EN
            last_grant_q <= CH_W'(NUM_CH - 1);
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pick_vld) begin
                        grant_q      <= pick;
`ifndef AMM_ARB_FIXED_PRIO_EN
                        last_grant_q <= pick;
`endif
                        state_q      <= CMD;
                    end
                end
                CMD: begin
                    if (rd_acc) begin
                        state_q <= IDLE;
                    end else if (wr_acc) begin
                        // burstcount 0 and 1 both mean a single beat.
                        if (gnt_bc > BURST_W'(1)) begin
                            wr_left_q <= gnt_bc - BURST_W'(1);
                            state_q   <= WR_BURST;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else if (!s_read && !s_write) begin
                        state_q <= IDLE;
                    end
                end
                WR_BURST: begin
                    if (wr_acc) begin
                        if (wr_left_q == BURST_W'(1)) begin
                            state_q <= IDLE;
                        end else begin
                            wr_left_q <= wr_left_q - BURST_W'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Read return path: the head tag names the channel that owns the returning beats.
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_W'(MAX_RD));
    assign head       = tag_mem[rd_ptr_q];
    assign rd_hit     = s_readdatavalid & ~fifo_empty;
    assign last_beat  = ((beat_q + BURST_W'(1)) == head.bc);
    assign push       = rd_acc;
    assign pop        = rd_hit & last_beat;
    assign push_tag   = '{ch: grant_q, bc: (gnt_bc == '0) ? BURST_W'(1) : gnt_bc};
    assign m_readdata = s_readdata;

    // Steer read data valid to the head channel; beats with no tag are dropped.
    always_comb begin
        m_readdatavalid = '0;
        if (rd_hit) begin
            m_readdatavalid[head.ch] = 1'b1;
        end
    end

    // Tag storage write port.
    always_ff @(posedge clk) begin
        // NOTE: the tag array has no reset; occupancy lives in count_q, so stale entries are never read.
        if (push) begin
            tag_mem[wr_ptr_q] <= push_tag;
        end
    end

    // Tag FIFO pointers, occupancy and head beat counter; reset flushes everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            beat_q   <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
            if (rd_hit) begin
                beat_q <= last_beat ? '0 : beat_q + BURST_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_amm_rr_arbiter.sv
// tb_amm_rr_arbiter: directed stimulus with a scoreboard. Stimulus pushes
// expected slave commands and expected read responses into queues; a monitor
// on the falling edge pops and compares whenever the DUT presents them.
module tb_amm_rr_arbiter;

    localparam int NUM_CH  = 4;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 64;
    localparam int BURST_W = 11;
    localparam int MAX_RD  = 8;
    localparam int BE_W    = DATA_W / 8;

    logic                         clk = 1'b0;
    logic                         rst;
    logic [NUM_CH*ADDR_W-1:0]     m_address;
    logic [NUM_CH-1:0]            m_read;
    logic [NUM_CH-1:0]            m_write;
    logic [NUM_CH*BE_W-1:0]       m_byteenable;
    logic [NUM_CH*BURST_W-1:0]    m_burstcount;
    logic [NUM_CH*DATA_W-1:0]     m_writedata;
    logic [NUM_CH-1:0]            m_waitrequest;
    logic [NUM_CH-1:0]            m_readdatavalid;
    logic [DATA_W-1:0]            m_readdata;
    logic [ADDR_W-1:0]            s_address;
    logic                         s_read;
    logic                         s_write;
    logic [BE_W-1:0]              s_byteenable;
    logic [BURST_W-1:0]           s_burstcount;
    logic [DATA_W-1:0]            s_writedata;
    logic                         s_readdatavalid;
    logic [DATA_W-1:0]            s_readdata;
    logic                         s_waitrequest;

    always #5 clk = ~clk;

    amm_rr_arbiter #(
        .NUM_CH (NUM_CH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .BURST_W(BURST_W),
        .MAX_RD (MAX_RD)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .m_address      (m_address),
        .m_read         (m_read),
        .m_write        (m_write),
        .m_byteenable   (m_byteenable),
        .m_burstcount   (m_burstcount),
        .m_writedata    (m_writedata),
        .m_waitrequest  (m_waitrequest),
        .m_readdatavalid(m_readdatavalid),
        .m_readdata     (m_readdata),
        .s_address      (s_address),
        .s_read         (s_read),
        .s_write        (s_write),
        .s_byteenable   (s_byteenable),
        .s_burstcount   (s_burstcount),
        .s_writedata    (s_writedata),
        .s_readdatavalid(s_readdatavalid),
        .s_readdata     (s_readdata),
        .s_waitrequest  (s_waitrequest)
    );

    typedef struct packed {
        logic               wr;
        logic [ADDR_W-1:0]  addr;
        logic [BURST_W-1:0] bc;
        logic [BE_W-1:0]    be;
        logic [DATA_W-1:0]  data;
    } cmd_t;

    typedef struct packed {
        logic [NUM_CH-1:0] vld;
        logic [DATA_W-1:0] data;
    } rsp_t;

    cmd_t cmd_q[$];
    rsp_t rsp_q[$];
    cmd_t mon_cmd;
    rsp_t mon_rsp;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [ADDR_W-1:0] wa(input int ch);
        return 32'h4000_0000 + 32'(ch) * 32'h100;
    endfunction

    function automatic logic [ADDR_W-1:0] ra(input int ch);
        return 32'h8000_0000 + 32'(ch) * 32'h100;
    endfunction

    function automatic logic [DATA_W-1:0] wd(input int ch, input int beat);
        return {16'hDA7A, 16'(ch), 32'(beat)};
    endfunction

    function automatic logic [DATA_W-1:0] rdat(input int n);
        return 64'hBEEF_0000_0000_0000 + 64'(n);
    endfunction

    function automatic logic [BE_W-1:0] be(input int ch);
        return 8'(17 * (ch + 1));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_wr(input int ch, input logic [DATA_W-1:0] d, input int bc);
        m_write[ch] = 1'b1;
        m_read[ch]  = 1'b0;
        m_address[ch*ADDR_W +: ADDR_W]     = wa(ch);
        m_writedata[ch*DATA_W +: DATA_W]   = d;
        m_burstcount[ch*BURST_W +: BURST_W] = BURST_W'(bc);
        m_byteenable[ch*BE_W +: BE_W]      = be(ch);
    endtask

    task automatic drive_rd(input int ch, input int bc);
        m_read[ch]  = 1'b1;
        m_write[ch] = 1'b0;
        m_address[ch*ADDR_W +: ADDR_W]     = ra(ch);
        m_burstcount[ch*BURST_W +: BURST_W] = BURST_W'(bc);
        m_byteenable[ch*BE_W +: BE_W]      = be(ch);
    endtask

    task automatic clr(input int ch);
        m_write[ch] = 1'b0;
        m_read[ch]  = 1'b0;
    endtask

    task automatic exp_wr(input int ch, input logic [DATA_W-1:0] d, input int bc);
        cmd_q.push_back('{wr: 1'b1, addr: wa(ch), bc: BURST_W'(bc), be: be(ch), data: d});
    endtask

    task automatic exp_rd(input int ch, input int bc);
        cmd_q.push_back('{wr: 1'b0, addr: ra(ch), bc: BURST_W'(bc), be: be(ch), data: '0});
    endtask

    // Returns one read beat from the slave model and records who must see it.
    task automatic ret_beat(input logic [NUM_CH-1:0] vld, input int n);
        rsp_q.push_back('{vld: vld, data: rdat(n)});
        s_readdatavalid = 1'b1;
        s_readdata      = rdat(n);
        tick();
    endtask

    // Monitor: compare every accepted slave command and every routed read beat.
    always @(negedge clk) begin
        if (!rst) begin
            if ((s_read || s_write) && !s_waitrequest) begin
                if (cmd_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_cmd: got wr=%0b addr=%0h, expected none (t=%0t)", s_write, s_address, $time);
                end else begin
                    mon_cmd = cmd_q.pop_front();
                    check("cmd_kind", s_write, mon_cmd.wr);
                    check("cmd_addr", s_address, mon_cmd.addr);
                    check("cmd_burstcount", s_burstcount, mon_cmd.bc);
                    check("cmd_byteenable", s_byteenable, mon_cmd.be);
                    if (mon_cmd.wr) check("cmd_writedata", s_writedata, mon_cmd.data);
                end
            end
            if (m_readdatavalid != '0) begin
                if (rsp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_rdv: got %0b, expected none (t=%0t)", m_readdatavalid, $time);
                end else begin
                    mon_rsp = rsp_q.pop_front();
                    check("rsp_valid", m_readdatavalid, mon_rsp.vld);
                    check("rsp_data", m_readdata, mon_rsp.data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        m_address = '0; m_read = '0; m_write = '0; m_byteenable = '0;
        m_burstcount = '0; m_writedata = '0;
        s_readdatavalid = 1'b0; s_readdata = '0; s_waitrequest = 1'b0;
        tick(); tick();
        check("rst_waitrequest", m_waitrequest, 4'hF);
        check("rst_s_read", s_read, 1'b0);
        check("rst_s_write", s_write, 1'b0);
        check("rst_rdv", m_readdatavalid, 4'h0);
        rst = 1'b0;
        tick();

        // A: four channels writing continuously -> grants 0,1,2,3,0,1,2,3.
        for (int c = 0; c < NUM_CH; c++) drive_wr(c, wd(c, 0), 1);
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < NUM_CH; c++) exp_wr(c, wd(c, 0), 1);
        tick();
        check("a_first_grant_ch0", m_waitrequest, 4'b1110);
        check("a_latency_write", s_write, 1'b1);
        check("a_latency_addr", s_address, wa(0));
        repeat (15) tick();
        for (int c = 0; c < NUM_CH; c++) clr(c);
        tick();

        // B: ch1 burst of 4 with a mid-burst idle cycle while ch0/ch2 request.
        drive_wr(0, wd(0, 1), 1);
        exp_wr(0, wd(0, 1), 1);
        for (int b = 0; b < 4; b++) exp_wr(1, wd(1, b), 4);
        exp_wr(2, wd(2, 1), 1);
        exp_wr(0, wd(0, 1), 1);
        tick(); tick();
        drive_wr(1, wd(1, 0), 4);
        drive_wr(2, wd(2, 1), 1);
        tick();
        check("b_grant_ch1", m_waitrequest, 4'b1101);
        tick();
        drive_wr(1, wd(1, 1), 4);
        tick();
        m_write[1] = 1'b0;
        #1;
        check("b_idle_beat_no_write", s_write, 1'b0);
        check("b_lock_held", m_waitrequest, 4'b1101);
        tick();
        drive_wr(1, wd(1, 2), 4);
        tick();
        drive_wr(1, wd(1, 3), 4);
        tick();
        clr(1);
        tick();
        check("b_grant_ch2", m_waitrequest, 4'b1011);
        tick();
        clr(2);
        tick();
        check("b_grant_ch0", m_waitrequest, 4'b1110);
        tick();
        clr(0);
        tick();

        // C: ch0 reads 3, ch3 reads 2, five beats back-to-back.
        drive_rd(0, 3); exp_rd(0, 3); exp_rd(3, 2);
        tick(); tick();
        clr(0); drive_rd(3, 2);
        tick(); tick();
        clr(3);
        for (int n = 0; n < 5; n++) ret_beat((n < 3) ? 4'b0001 : 4'b1000, n);
        s_readdatavalid = 1'b0;
        tick();

        // D: fill the tag FIFO, ch2 read stalls while ch1 write proceeds.
        drive_rd(0, 1);
        for (int k = 0; k < MAX_RD; k++) exp_rd(0, 1);
        repeat (16) tick();
        clr(0);
        drive_rd(2, 1); drive_wr(1, wd(1, 9), 1);
        exp_wr(1, wd(1, 9), 1); exp_rd(2, 1);
        tick();
        check("d_write_granted", m_waitrequest, 4'b1101);
        tick();
        clr(1);
        tick(); tick();
        check("d_read_stalled", m_waitrequest, 4'hF);
        check("d_no_slave_read", s_read, 1'b0);
        ret_beat(4'b0001, 10);
        s_readdatavalid = 1'b0;
        tick();
        check("d_read_unblocked", m_waitrequest, 4'b1011);
        check("d_slave_read", s_read, 1'b1);
        tick();
        clr(2);
        for (int n = 0; n < MAX_RD; n++) ret_beat((n < MAX_RD - 1) ? 4'b0001 : 4'b0100, 20 + n);
        s_readdatavalid = 1'b0;
        tick();

        // E: slave stalls a ch0 read for 5 cycles; exactly one tag is pushed.
        s_waitrequest = 1'b1;
        drive_rd(0, 2); exp_rd(0, 2);
        tick();
        for (int k = 0; k < 5; k++) begin
            check("e_stall_wait", m_waitrequest, 4'hF);
            check("e_stall_read", s_read, 1'b1);
            check("e_stall_addr", s_address, ra(0));
            tick();
        end
        s_waitrequest = 1'b0;
        #1;
        check("e_released", m_waitrequest, 4'hE);
        tick();
        clr(0);
        ret_beat(4'b0001, 30);
        ret_beat(4'b0001, 31);
        s_readdatavalid = 1'b0;
        tick();

        // Push and pop on the same edge, then a beat with an empty FIFO.
        drive_rd(0, 1); exp_rd(0, 1); exp_rd(1, 1);
        tick(); tick();
        clr(0); drive_rd(1, 1);
        tick();
        ret_beat(4'b0001, 40);
        clr(1);
        ret_beat(4'b0010, 41);
        s_readdata = rdat(42);
        @(negedge clk);
        check("pp_empty_ignored", m_readdatavalid, 4'h0);
        tick();
        s_readdatavalid = 1'b0;
        tick();

        // F: reset during a ch0 burst of 8 after 3 beats, with a read outstanding.
        drive_rd(2, 1); exp_rd(2, 1);
        for (int b = 0; b < 3; b++) exp_wr(0, wd(0, 10 + b), 8);
        exp_wr(0, wd(0, 20), 1);
        exp_wr(1, wd(1, 20), 1);
        tick(); tick();
        clr(2); drive_wr(0, wd(0, 10), 8);
        tick(); tick();
        drive_wr(0, wd(0, 11), 8);
        tick();
        drive_wr(0, wd(0, 12), 8);
        tick();
        rst = 1'b1;
        clr(0);
        tick();
        check("f_rst_no_write", s_write, 1'b0);
        check("f_rst_idle", m_waitrequest, 4'hF);
        rst = 1'b0;
        s_readdatavalid = 1'b1;
        s_readdata = rdat(50);
        @(negedge clk);
        check("f_flushed_rdv", m_readdatavalid, 4'h0);
        tick();
        s_readdatavalid = 1'b0;
        drive_wr(0, wd(0, 20), 1);
        drive_wr(1, wd(1, 20), 1);
        tick();
        check("f_next_grant_ch0", m_waitrequest, 4'b1110);
        tick();
        clr(0);
        tick(); tick();
        clr(1);
        tick(); tick();

        check("cmd_queue_drained", cmd_q.size(), 0);
        check("rsp_queue_drained", rsp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
